// File: rtl/serial_mag_comp_pkg.sv
// Shared types and helpers for the serial magnitude comparator.
//   state_t   : FSM encoding (IDLE, CMP, DONE)
//   idx_width : bit width of the MSB-first bit index for a given operand width
package serial_mag_comp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Index register width; a 1-bit index still needs one bit.
    function automatic int unsigned idx_width(input int unsigned width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/serial_mag_comp_comp_bit.sv
// Combinational single-bit unsigned compare; exactly one output is high.
//   x, y : input bits
//   eq   : x == y
//   gt   : x > y
//   lt   : x < y
module comp_bit (
    input  logic x,
    input  logic y,
    output logic eq,
    output logic gt,
    output logic lt
);

    assign eq = ~(x ^ y);
    assign gt = x & ~y;
    assign lt = ~x & y;

endmodule

// File: rtl/serial_mag_comp.sv
// Bit-serial unsigned magnitude comparator, MSB first, one bit per clock,
// stopping at the first differing bit.
//   clk, rst       : clock, synchronous active-high reset
//   start          : compare request, sampled when not busy
//   a, b           : operands, captured on the accepted start
//   busy           : compare in progress
//   done           : one-cycle pulse, flags freshly updated
//   equal/greater/lower : one-hot result of the last completed compare
module serial_mag_comp
    import serial_mag_comp_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             equal,
    output logic             greater,
    output logic             lower
);

    localparam int unsigned     IW      = idx_width(WIDTH);
    localparam logic [IW-1:0]   IDX_MAX = IW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             busy_d, done_d, equal_d, greater_d, lower_d;
    logic             bit_eq, bit_gt, bit_lt;

    // Single shared bit comparator, fed by the currently indexed operand bits.
    comp_bit u_comp_bit (
        .x  (a_q[idx_q]),
        .y  (b_q[idx_q]),
        .eq (bit_eq),
        .gt (bit_gt),
        .lt (bit_lt)
    );

    // Next-state and next-output logic; flags hold unless a compare completes.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        a_d       = a_q;
        b_d       = b_q;
        busy_d    = busy;
        done_d    = 1'b0;
        equal_d   = equal;
        greater_d = greater;
        lower_d   = lower;

        case (state_q)
            IDLE, DONE: begin
                busy_d = 1'b0;
                if (start) begin
                    state_d = CMP;
                    a_d     = a;
                    b_d     = b;
                    idx_d   = IDX_MAX;
                    busy_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            CMP: begin
                if (!bit_eq) begin
                    state_d   = DONE;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    equal_d   = 1'b0;
                    greater_d = bit_gt;
                    lower_d   = bit_lt;
                end else if (idx_q == '0) begin
                    state_d   = DONE;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    equal_d   = 1'b1;
                    greater_d = 1'b0;
                    lower_d   = 1'b0;
                end else begin
                    idx_d = idx_q - IW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, operand, index and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= IDX_MAX;
            a_q     <= '0;
            b_q     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            equal   <= 1'b0;
            greater <= 1'b0;
            lower   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            busy    <= busy_d;
            done    <= done_d;
            equal   <= equal_d;
            greater <= greater_d;
            lower   <= lower_d;
        end
    end

endmodule

// File: tb/tb_serial_mag_comp.sv
// Self-checking bench for serial_mag_comp (WIDTH=8): a transaction-level model
// predicts busy/done/flags every cycle; directed cases pin latency and flags.
module tb_serial_mag_comp;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a, b;
    logic         busy, done, equal, greater, lower;

    int nvec  = 0;
    int nfail = 0;
    bit chk_en = 1'b0;

    serial_mag_comp #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .equal   (equal),
        .greater (greater),
        .lower   (lower)
    );

    always #5 clk = ~clk;

    // Result as {equal, greater, lower} from plain arithmetic.
    function automatic logic [2:0] ref_flags(input logic [W-1:0] x, input logic [W-1:0] y);
        if (x == y) return 3'b100;
        if (x > y)  return 3'b010;
        return 3'b001;
    endfunction

    // Edges from accept to decision: W - (highest differing bit), or W if equal.
    function automatic int ref_lat(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W-1:0] d;
        d = x ^ y;
        for (int i = W - 1; i >= 0; i--)
            if (d[i]) return W - i;
        return W;
    endfunction

    // Transaction-level reference: countdown to a precomputed result.
    bit         m_busy, m_done;
    logic [2:0] m_flags, m_res;
    int         m_cnt;

    always @(posedge clk) begin
        if (rst) begin
            m_busy  = 1'b0;
            m_done  = 1'b0;
            m_flags = 3'b000;
            m_cnt   = 0;
        end else if (m_busy) begin
            m_cnt = m_cnt - 1;
            if (m_cnt == 0) begin
                m_busy  = 1'b0;
                m_done  = 1'b1;
                m_flags = m_res;
            end
        end else begin
            m_done = 1'b0;
            if (start) begin
                m_res  = ref_flags(a, b);
                m_cnt  = ref_lat(a, b);
                m_busy = 1'b1;
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            nvec++;
            if ({busy, done, equal, greater, lower} !== {m_busy, m_done, m_flags}) begin
                nfail++;
                $display("FAIL cycle_model t=%0t got busy/done/eq/gt/lt=%b expected %b",
                         $time, {busy, done, equal, greater, lower},
                         {m_busy, m_done, m_flags});
            end
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        nvec++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s t=%0t got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    // Called at a negedge: present operands and let the next edge accept them.
    task automatic launch(input logic [W-1:0] x, input logic [W-1:0] y);
        start = 1'b1;
        a     = x;
        b     = y;
        @(posedge clk);
    endtask

    // Follow a compare after its accept edge; returns at the negedge of the done cycle.
    task automatic wait_done(input int pulse_at, output int lat, output int bcnt,
                             output logic [2:0] f1);
        lat  = -1;
        bcnt = 0;
        f1   = 3'b000;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (n == 1) begin
                start = 1'b0;
                a     = W'($urandom);
                b     = W'($urandom);
                f1    = {equal, greater, lower};
            end
            if (n == pulse_at) begin
                start = 1'b1;
                a     = W'($urandom);
                b     = W'($urandom);
            end
            if (n == pulse_at + 1) start = 1'b0;
            if (done) begin
                lat = n - 1;
                break;
            end
            if (busy) bcnt++;
        end
    endtask

    int         lat, bc, ndone;
    logic [2:0] f1;
    logic [W-1:0] x, y;

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        chk("reset_outputs", int'({busy, done, equal, greater, lower}), 0);
        rst = 1'b0;
        @(negedge clk);

        // MSB differs: fastest path.
        launch(8'hA5, 8'h25);
        wait_done(0, lat, bc, f1);
        chk("msb_latency", lat, 1);
        chk("msb_busy_cycles", bc, 1);
        chk("msb_flags", int'({equal, greater, lower}), 3'b010);
        @(negedge clk);
        chk("done_one_cycle", int'(done), 0);

        // Equal operands: slowest path.
        launch(8'h3C, 8'h3C);
        wait_done(0, lat, bc, f1);
        chk("eq_latency", lat, 8);
        chk("eq_busy_cycles", bc, 8);
        chk("eq_flags", int'({equal, greater, lower}), 3'b100);
        @(negedge clk);

        // LSB differs.
        launch(8'h10, 8'h11);
        wait_done(0, lat, bc, f1);
        chk("lsb_latency", lat, 8);
        chk("lsb_flags", int'({equal, greater, lower}), 3'b001);
        @(negedge clk);

        // Start pulsed mid-compare is ignored.
        launch(8'h80, 8'h81);
        wait_done(3, lat, bc, f1);
        chk("midstart_latency", lat, 8);
        chk("midstart_flags", int'({equal, greater, lower}), 3'b001);
        ndone = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("midstart_no_extra_done", ndone, 0);

        // First compare gives greater, then back-to-back start in the done cycle.
        launch(8'h81, 8'h80);
        wait_done(0, lat, bc, f1);
        chk("b2b_first_flags", int'({equal, greater, lower}), 3'b010);
        launch(8'h10, 8'h11);
        wait_done(0, lat, bc, f1);
        chk("b2b_held_flags", int'(f1), 3'b010);
        chk("b2b_second_latency", lat, 8);
        chk("b2b_second_flags", int'({equal, greater, lower}), 3'b001);
        launch(8'h01, 8'h00);
        wait_done(0, lat, bc, f1);
        chk("b2b_held_lower", int'(f1), 3'b001);
        chk("b2b_third_latency", lat, 8);
        chk("b2b_third_flags", int'({equal, greater, lower}), 3'b010);
        @(negedge clk);

        // Reset in the middle of an equal compare (idx=4).
        launch(8'h3C, 8'h3C);
        repeat (4) begin
            @(negedge clk);
            start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        chk("midreset_outputs", int'({busy, done, equal, greater, lower}), 0);
        rst = 1'b0;
        ndone = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("midreset_no_done", ndone, 0);

        // Reset beats start.
        start = 1'b1;
        rst   = 1'b1;
        a     = 8'hFF;
        b     = 8'h00;
        @(negedge clk);
        chk("rst_over_start_busy", int'(busy), 0);
        start = 1'b0;
        rst   = 1'b0;
        @(negedge clk);

        // Randomized compares, biased toward equal and single-bit differences.
        for (int i = 0; i < 200; i++) begin
            x = W'($urandom);
            case ($urandom_range(0, 3))
                0:       y = x;
                1:       y = x ^ (W'(1) << $urandom_range(0, W - 1));
                default: y = W'($urandom);
            endcase
            launch(x, y);
            wait_done(0, lat, bc, f1);
            chk("rand_latency", lat, ref_lat(x, y));
            chk("rand_flags", int'({equal, greater, lower}), int'(ref_flags(x, y)));
            if ($urandom_range(0, 2) != 0) repeat ($urandom_range(1, 3)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
